// File: rtl/mcu_cfg_rx.sv
// 8N1 receiver for the MCU -> FPGA serial line, plus a two-byte (address, data)
// frame parser that turns each complete frame into a one-cycle config write.
module mcu_cfg_rx #(
    parameter int CLK_PER_BIT  = 100,
    parameter int TIMEOUT_CLKS = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       new_rx_data,
    output logic       frame_err,
    output logic [6:0] cfg_addr,
    output logic [7:0] cfg_data,
    output logic       cfg_we,
    output logic       busy
);
    localparam int CTR_W = $clog2(CLK_PER_BIT);
    localparam int TMO_W = ($clog2(TIMEOUT_CLKS + 1) > 16) ? $clog2(TIMEOUT_CLKS + 1) : 16;
    localparam logic [CTR_W-1:0] HALF_LAST = CTR_W'(CLK_PER_BIT / 2 - 1);
    localparam logic [CTR_W-1:0] BIT_LAST  = CTR_W'(CLK_PER_BIT - 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CLKS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } rx_state_e;

    typedef enum logic {
        P_ADDR = 1'b0,
        P_DATA = 1'b1
    } p_state_e;

    (* ASYNC_REG = "TRUE" *) logic rx_meta_q;
    (* ASYNC_REG = "TRUE" *) logic rx_s_q;

    rx_state_e        rx_state_q;
    logic [CTR_W-1:0] ctr_q;
    logic [CTR_W-1:0] ctr_d;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q;
    logic [7:0]       rx_data_q;
    logic             new_rx_data_q;
    logic             frame_err_q;

    p_state_e         p_state_q;
    logic [6:0]       addr_lat_q;
    logic [TMO_W-1:0] tmo_q;
    logic [TMO_W-1:0] tmo_d;
    logic [6:0]       cfg_addr_q;
    logic [7:0]       cfg_data_q;
    logic             cfg_we_q;

    assign ctr_d = ctr_q + {{(CTR_W-1){1'b0}}, 1'b1};
    assign tmo_d = tmo_q + {{(TMO_W-1){1'b0}}, 1'b1};

    // Two-flop synchroniser; idles high so reset does not look like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Byte receiver: mid-bit sampling, one strobe per byte, one frame_err per break.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q    <= S_IDLE;
            ctr_q         <= {CTR_W{1'b0}};
            bit_q         <= 3'd0;
            shift_q       <= 8'h00;
            rx_data_q     <= 8'h00;
            new_rx_data_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            new_rx_data_q <= 1'b0;
            frame_err_q   <= 1'b0;
            case (rx_state_q)
                S_IDLE: begin
                    if (!rx_s_q) begin
                        rx_state_q <= S_START;
                        ctr_q      <= {CTR_W{1'b0}};
                    end
                end
                S_START: begin
                    if (ctr_q == HALF_LAST) begin
                        ctr_q <= {CTR_W{1'b0}};
                        bit_q <= 3'd0;
                        rx_state_q <= rx_s_q ? S_IDLE : S_DATA;
                    end else begin
                        ctr_q <= ctr_d;
                    end
                end
                S_DATA: begin
                    if (ctr_q == BIT_LAST) begin
                        shift_q <= {rx_s_q, shift_q[7:1]};
                        ctr_q   <= {CTR_W{1'b0}};
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            rx_state_q <= S_STOP;
                        end
                    end else begin
                        ctr_q <= ctr_d;
                    end
                end
                S_STOP: begin
                    if (ctr_q == BIT_LAST) begin
                        ctr_q <= {CTR_W{1'b0}};
                        if (rx_s_q) begin
                            rx_data_q     <= shift_q;
                            new_rx_data_q <= 1'b1;
                            rx_state_q    <= S_IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            rx_state_q  <= S_BREAK;
                        end
                    end else begin
                        ctr_q <= ctr_d;
                    end
                end
                S_BREAK: begin
                    if (rx_s_q) begin
                        rx_state_q <= S_IDLE;
                    end
                end
                default: begin
                    rx_state_q <= S_IDLE;
                    ctr_q      <= {CTR_W{1'b0}};
                end
            endcase
        end
    end

    // Frame parser: address byte (bit7 set) then any data byte, within the timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_state_q  <= P_ADDR;
            addr_lat_q <= 7'd0;
            tmo_q      <= {TMO_W{1'b0}};
            cfg_addr_q <= 7'd0;
            cfg_data_q <= 8'h00;
            cfg_we_q   <= 1'b0;
        end else begin
            cfg_we_q <= 1'b0;
            case (p_state_q)
                P_ADDR: begin
                    if (new_rx_data_q && rx_data_q[7]) begin
                        addr_lat_q <= rx_data_q[6:0];
                        tmo_q      <= {{(TMO_W-1){1'b0}}, 1'b1};
                        p_state_q  <= P_DATA;
                    end
                end
                P_DATA: begin
                    // A data strobe on the timeout cycle itself still wins.
                    if (new_rx_data_q) begin
                        cfg_addr_q <= addr_lat_q;
                        cfg_data_q <= rx_data_q;
                        cfg_we_q   <= 1'b1;
                        p_state_q  <= P_ADDR;
                    end else if (frame_err_q || (tmo_q == TMO_LAST)) begin
                        p_state_q <= P_ADDR;
                    end else begin
                        tmo_q <= tmo_d;
                    end
                end
                default: begin
                    p_state_q <= P_ADDR;
                end
            endcase
        end
    end

    assign rx_data     = rx_data_q;
    assign new_rx_data = new_rx_data_q;
    assign frame_err   = frame_err_q;
    assign cfg_addr    = cfg_addr_q;
    assign cfg_data    = cfg_data_q;
    assign cfg_we      = cfg_we_q;
    assign busy        = (rx_state_q != S_IDLE) || (p_state_q == P_DATA);

endmodule

// File: tb/tb_mcu_cfg_rx.sv
// Directed + randomized bench for mcu_cfg_rx, checked against a frame-level
// reference model driven by the bench's own transmit times.
module tb_mcu_cfg_rx;
    localparam int CPB = 100;
    localparam int TMO = 3000;
    localparam int LAT_MIN = 952;
    localparam int LAT_MAX = 955;
    localparam int LAT_NOM = 953;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       new_rx_data;
    logic       frame_err;
    logic [6:0] cfg_addr;
    logic [7:0] cfg_data;
    logic       cfg_we;
    logic       busy;

    mcu_cfg_rx #(.CLK_PER_BIT(CPB), .TIMEOUT_CLKS(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx),
        .rx_data(rx_data), .new_rx_data(new_rx_data), .frame_err(frame_err),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_we(cfg_we), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed strobes, accumulated for the whole run
    logic [7:0]  obs_rx[$];
    int          obs_rx_cyc[$];
    logic [14:0] obs_we[$];
    int          obs_fe = 0;
    int          we_consec = 0;
    logic        prev_we = 1'b0;

    always @(negedge clk) begin
        if (new_rx_data) begin
            obs_rx.push_back(rx_data);
            obs_rx_cyc.push_back(cyc);
        end
        if (frame_err) obs_fe <= obs_fe + 1;
        if (cfg_we) obs_we.push_back({cfg_addr, cfg_data});
        if (cfg_we && prev_we) we_consec <= we_consec + 1;
        prev_we <= cfg_we;
    end

    // Transmitted bytes and the reference model state
    logic [7:0]  ev_byte[$];
    bit          ev_ok[$];
    int          ev_cyc[$];
    logic [7:0]  exp_rx[$];
    int          exp_rx_cyc[$];
    logic [14:0] exp_we[$];
    int          exp_fe = 0;
    bit          m_pend = 1'b0;
    logic [6:0]  m_addr = 7'd0;
    int          m_cyc = 0;
    logic [7:0]  m_last_rx = 8'h00;
    logic [14:0] m_last_we = 15'd0;
    int          chk_rx = 0;
    int          chk_we = 0;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic line(input logic v, input int n);
        rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        ev_byte.push_back(b);
        ev_ok.push_back(stop_ok);
        ev_cyc.push_back(cyc);
        line(1'b0, CPB);
        for (int i = 0; i < 8; i++) line(b[i], CPB);
        line(stop_ok, CPB);
    endtask

    // Frame rules: address byte has bit7 set; the next good byte within TMO clocks is data.
    task automatic model_drain();
        logic [7:0] b;
        bit ok;
        int c;
        while (ev_byte.size() > 0) begin
            b = ev_byte.pop_front();
            ok = ev_ok.pop_front();
            c = ev_cyc.pop_front();
            if (!ok) begin
                exp_fe++;
                m_pend = 1'b0;
            end else begin
                exp_rx.push_back(b);
                exp_rx_cyc.push_back(c);
                m_last_rx = b;
                if (m_pend && (c - m_cyc) <= TMO) begin
                    exp_we.push_back({m_addr, b});
                    m_last_we = {m_addr, b};
                    m_pend = 1'b0;
                end else if (b[7]) begin
                    m_pend = 1'b1;
                    m_addr = b[6:0];
                    m_cyc = c;
                end else begin
                    m_pend = 1'b0;
                end
            end
        end
    endtask

    task automatic model_reset();
        ev_byte.delete();
        ev_ok.delete();
        ev_cyc.delete();
        m_pend = 1'b0;
        m_last_rx = 8'h00;
        m_last_we = 15'd0;
    endtask

    task automatic check_all(input string tag);
        int n;
        int lat;
        int age;
        model_drain();
        check({tag, "_rx_count"}, 32'(obs_rx.size()), 32'(exp_rx.size()));
        n = (obs_rx.size() < exp_rx.size()) ? obs_rx.size() : exp_rx.size();
        for (int i = chk_rx; i < n; i++) begin
            check({tag, "_rx_byte"}, 32'(obs_rx[i]), 32'(exp_rx[i]));
            lat = obs_rx_cyc[i] - exp_rx_cyc[i];
            check({tag, "_rx_latency_ok"}, 32'(lat >= LAT_MIN && lat <= LAT_MAX), 32'd1);
        end
        chk_rx = n;
        check({tag, "_fe_count"}, 32'(obs_fe), 32'(exp_fe));
        check({tag, "_we_count"}, 32'(obs_we.size()), 32'(exp_we.size()));
        n = (obs_we.size() < exp_we.size()) ? obs_we.size() : exp_we.size();
        for (int i = chk_we; i < n; i++) begin
            check({tag, "_we_addr_data"}, 32'(obs_we[i]), 32'(exp_we[i]));
        end
        chk_we = n;
        check({tag, "_rx_data_hold"}, 32'(rx_data), 32'(m_last_rx));
        check({tag, "_cfg_hold"}, 32'({cfg_addr, cfg_data}), 32'(m_last_we));
        check({tag, "_we_consecutive"}, 32'(we_consec), 32'd0);
        age = cyc - (m_cyc + LAT_NOM);
        if (!m_pend || age > TMO + 10) check({tag, "_busy"}, 32'(busy), 32'd0);
        else if (age < TMO - 10) check({tag, "_busy"}, 32'(busy), 32'd1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog run exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        bit ok;
        logic [7:0] rb;

        rst_n = 1'b0;
        rx = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("reset_outputs", 32'({rx_data, new_rx_data, frame_err, cfg_addr, cfg_data, cfg_we, busy}), 32'd0);
        rst_n = 1'b1;
        line(1'b1, 5);

        // Single address byte leaves the parser waiting for data
        send_byte(8'hA5, 1'b1);
        line(1'b1, 5);
        check_all("single_a5");
        line(1'b1, TMO + 10);
        check_all("single_a5_expired");

        // Back-to-back address/data frame
        send_byte(8'h83, 1'b1);
        send_byte(8'h5C, 1'b1);
        line(1'b1, 5);
        check_all("frame_83_5c");

        // Low stop bit followed by a long break
        send_byte(8'h81, 1'b0);
        line(1'b0, 30 * CPB);
        line(1'b1, CPB);
        check_all("break");
        send_byte(8'h81, 1'b1);
        send_byte(8'h01, 1'b1);
        line(1'b1, 5);
        check_all("after_break");

        // Short low glitch on an idle line
        line(1'b0, 20);
        line(1'b1, 60);
        check("glitch_busy", 32'(busy), 32'd0);
        check_all("glitch");

        // Data byte far too late, then a prompt pair
        send_byte(8'h82, 1'b1);
        line(1'b1, TMO + 1);
        send_byte(8'h11, 1'b1);
        line(1'b1, 5);
        check_all("timeout_drop");
        send_byte(8'h82, 1'b1);
        send_byte(8'h11, 1'b1);
        line(1'b1, 5);
        check_all("timeout_prompt");

        // Data strobe exactly TMO clocks after the address strobe, then one clock later
        send_byte(8'h85, 1'b1);
        line(1'b1, TMO - 10 * CPB);
        send_byte(8'h3C, 1'b1);
        line(1'b1, 5);
        check_all("tmo_edge_accept");
        send_byte(8'h86, 1'b1);
        line(1'b1, TMO - 10 * CPB + 1);
        send_byte(8'h3D, 1'b1);
        line(1'b1, 5);
        check_all("tmo_edge_drop");

        // Randomized byte stream with occasional bad stop bits
        for (int k = 0; k < 12; k++) begin
            b = 8'($urandom);
            if ((k % 2) == 0) b[7] = ($urandom_range(0, 3) != 0);
            ok = ($urandom_range(0, 9) != 0);
            send_byte(b, ok);
            if (!ok) line(1'b1, 20 + int'($urandom_range(0, 100)));
            else line(1'b1, int'($urandom_range(0, 40)));
        end
        line(1'b1, 5);
        check_all("random");

        // Reset in the middle of bit 4
        rb = 8'h84;
        line(1'b0, CPB);
        for (int i = 0; i < 4; i++) line(rb[i], CPB);
        line(rb[4], CPB / 2);
        rst_n = 1'b0;
        line(rb[4], 3);
        check("midbyte_reset_outputs", 32'({rx_data, new_rx_data, frame_err, cfg_addr, cfg_data, cfg_we, busy}), 32'd0);
        rx = 1'b1;
        line(1'b1, 3);
        rst_n = 1'b1;
        model_reset();
        line(1'b1, 12 * CPB);
        check_all("post_reset_quiet");
        send_byte(8'h84, 1'b1);
        send_byte(8'hFF, 1'b1);
        line(1'b1, 5);
        check_all("post_reset_frame");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mcu_cfg_rx.md
# mcu_cfg_rx

Serial receive path from the board MCU to the FPGA, the counterpart of the existing FPGA→MCU config-byte transmit path. Runs in the `sys_clock` domain. Deserialises 8N1 bytes from the MCU `rx` pin and parses two-byte register-write frames (address, data) into single-cycle config-write strobes for downstream config registers. Byte-level outputs are also exposed for debug and for future consumers.

## Interface
Parameters:
- CLK_PER_BIT, 100, sys clocks per serial bit (50 MHz / 500 kbaud); must be ≥ 4 and even.
- TIMEOUT_CLKS, 50000, clocks allowed between the address byte's strobe and the data byte's strobe before the frame is dropped.

Ports:
- clk  in  1  sys_clock, the 50 MHz board clock.
- rst_n  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- rx  in  1  serial line from the MCU. Asynchronous; idles high.
- rx_data  out  8  last good byte received. Reset value 0x00.
- new_rx_data  out  1  one-cycle strobe marking rx_data valid. Reset value 0.
- frame_err  out  1  one-cycle strobe when the stop bit is sampled low. Reset value 0.
- cfg_addr  out  7  register address of the last completed frame. Reset value 0.
- cfg_data  out  8  data of the last completed frame. Reset value 0x00.
- cfg_we  out  1  one-cycle write strobe. Reset value 0.
- busy  out  1  high while not in IDLE, or while a frame is half received. Reset value 0.

## Operation
- Synchronisation: `rx` passes through a 2-flop synchroniser (ASYNC_REG) to give `rx_s`. Both flops reset to 1.
- Bit counter: `ctr`, $clog2(CLK_PER_BIT) bits wide. Bit index: 3 bits.
- Receiver FSM:
  - IDLE: when `rx_s`=0, go to START with ctr=0.
  - START: ctr increments. At ctr = CLK_PER_BIT/2−1, sample `rx_s`. If 0, go to DATA with ctr=0 and bit=0. If 1 (glitch or false start), go to IDLE with no strobe.
  - DATA: at ctr = CLK_PER_BIT−1, shift `rx_s` into a shift register (LSB first), clear ctr, increment bit. After bit 7 is captured, go to STOP.
  - STOP: at ctr = CLK_PER_BIT−1, sample `rx_s`.
    - If 1: rx_data ← shift register, pulse new_rx_data, go to IDLE.
    - If 0: pulse frame_err, leave rx_data unchanged, go to BREAK.
  - BREAK: wait for `rx_s`=1, then go to IDLE. A held-low line (break) produces exactly one frame_err.
- Frame parser (consumes new_rx_data and frame_err):
  - P_ADDR: a byte with bit7=1 latches addr[6:0] and moves to P_DATA. A byte with bit7=0 is discarded.
  - P_DATA: the next good byte, any value, becomes data. cfg_addr and cfg_data are updated and cfg_we pulses. Return to P_ADDR.
  - P_DATA timeout: a 16-bit-or-wider counter reaching TIMEOUT_CLKS returns the parser to P_ADDR with no write.
  - P_DATA frame_err: return to P_ADDR with no write.
- cfg_addr and cfg_data change only on the cycle cfg_we asserts; otherwise they hold.
- Reset mid-byte or mid-frame: everything returns to the reset values immediately. A partially received byte is never emitted.

## Timing
- Start-edge detect happens 2–3 clocks after the line falls (synchroniser delay).
- Mid-stop sample is 9.5×CLK_PER_BIT clocks after the detected start edge.
- new_rx_data / frame_err assert on the cycle after the stop-bit sample, for exactly 1 clock.
- cfg_we asserts the cycle after the data byte's new_rx_data, for 1 clock. It is never asserted on two consecutive cycles.
- Back-to-back bytes: a start bit that immediately follows the stop bit is detected. IDLE is re-entered at mid-stop, so ≥0.5 bit of margin remains.
- Timeout boundary: the data byte's new_rx_data on the same cycle the counter hits TIMEOUT_CLKS is accepted (data wins).
- Data-path latency is a fixed count of clocks. There is no backpressure: consumers must accept each strobe on the cycle it occurs.

## Test plan
- Single byte 0xA5 at CLK_PER_BIT=100 → new_rx_data pulses once, rx_data=0xA5, frame_err=0, cfg_we=0, parser in P_DATA with addr 0x25.
- Frame 0x83,0x5C → one cfg_we pulse with cfg_addr=0x03, cfg_data=0x5C, and exactly 2 new_rx_data pulses.
- 0x81 sent with a low stop bit, then the line held low for 30 bit times → exactly 1 frame_err, no new_rx_data, rx_data unchanged. After the line returns high, frame 0x81,0x01 yields cfg_we with addr 0x01, data 0x01.
- Low glitch of 20 clocks on idle `rx` → no strobes, FSM back in IDLE, busy=0 within 60 clocks.
- 0x82 then 0x11 sent after TIMEOUT_CLKS+1 clocks → no cfg_we. A following 0x82,0x11 pair sent promptly → cfg_we with addr 0x02, data 0x11.
- rst_n asserted during bit 4 of a byte, released, then frame 0x84,0xFF → all outputs 0 during reset, no spurious strobe, then cfg_we with addr 0x04, data 0xFF.
